// File: rtl/fifo_pkg.sv
// Shared helpers and defaults for the async FIFO write side.
// Gray conversions take zero-extended values up to 32 bits; callers size-cast the result.
package fifo_pkg;
   localparam int ADDR_WIDTH_DEF = 8;
   localparam int DATA_WIDTH_DEF = 8;
   localparam int PTR_MAX_W      = 32;

   typedef logic [ADDR_WIDTH_DEF:0] ptr_t;

   function automatic logic [PTR_MAX_W-1:0] bin2gray(input logic [PTR_MAX_W-1:0] b);
      return b ^ (b >> 1);
   endfunction

   function automatic logic [PTR_MAX_W-1:0] gray2bin(input logic [PTR_MAX_W-1:0] g);
      logic [PTR_MAX_W-1:0] b;
      b[PTR_MAX_W-1] = g[PTR_MAX_W-1];
      for (int i = PTR_MAX_W-2; i >= 0; i--) begin
         b[i] = b[i+1] ^ g[i];
      end
      return b;
   endfunction
endpackage

// File: rtl/rr_arbiter.sv
// Round-robin request picker: searches upward (circular) starting after i_rr_last.
module rr_arbiter #(
   parameter int NUM_REQ = 4
) (
   input  logic [NUM_REQ-1:0]         i_req,
   input  logic [$clog2(NUM_REQ)-1:0] i_rr_last,
   output logic [NUM_REQ-1:0]         o_gnt,
   output logic [$clog2(NUM_REQ)-1:0] o_idx
);
   localparam int IW = $clog2(NUM_REQ);

   logic          w_found;
   logic [IW-1:0] w_j;

   always_comb begin
      o_gnt   = '0;
      o_idx   = i_rr_last;
      w_found = 1'b0;
      w_j     = '0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         w_j = IW'((int'(i_rr_last) + k) % NUM_REQ);
         if (!w_found && i_req[w_j]) begin
            w_found    = 1'b1;
            o_gnt[w_j] = 1'b1;
            o_idx      = w_j;
         end
      end
   end
endmodule

// File: rtl/fifo_wr_arbiter.sv
// Async FIFO write side: arbitrates requesters, owns write pointers and full flags.
// Optional FIFO_WR_ARB_STATS_EN adds saturating stall/grant counters.
module fifo_wr_arbiter
   import fifo_pkg::*;
#(
   parameter int Addr_Width   = ADDR_WIDTH_DEF,
   parameter int Data_Width   = DATA_WIDTH_DEF,
   parameter int NUM_REQ      = 4,
   parameter int AFULL_THRESH = 4
) (
   input  logic                          wrclk,
   input  logic                          wr_rst,
   input  logic [NUM_REQ-1:0]            req,
   input  logic [NUM_REQ*Data_Width-1:0] wdata_in,
   input  logic [Addr_Width:0]           rptr_sync,
   output logic [NUM_REQ-1:0]            gnt,
   output logic                          wen,
   output logic [Addr_Width-1:0]         waddr,
   output logic [Data_Width-1:0]         wdata,
   output logic [Addr_Width:0]           wptr,
   output logic                          full,
   output logic                          almost_full
`ifdef FIFO_WR_ARB_STATS_EN
   ,
   output logic [15:0]                   stall_cnt,
   output logic [NUM_REQ*16-1:0]         gnt_cnt
`endif
);
   localparam int          PW    = Addr_Width + 1;
   localparam int          IW    = $clog2(NUM_REQ);
   localparam logic [31:0] DEPTH = 32'(1) << Addr_Width;

   logic [PW-1:0]         r_wbin;
   logic [IW-1:0]         r_rr_last;
   logic [NUM_REQ-1:0]    w_arb_gnt;
   logic [IW-1:0]         w_arb_idx;
   logic                  w_accept;
   logic [PW-1:0]         w_wbin_next;
   logic [PW-1:0]         w_wgray_next;
   logic [PW-1:0]         w_rbin;
   logic [PW-1:0]         w_fill;
   logic [Data_Width-1:0] w_sel_data;
   logic                  w_full_next;
   logic                  w_afull_next;

   rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr_arbiter (
      .i_req     (req),
      .i_rr_last (r_rr_last),
      .o_gnt     (w_arb_gnt),
      .o_idx     (w_arb_idx)
   );

   assign gnt          = (wr_rst || full) ? '0 : w_arb_gnt;
   assign w_accept     = |gnt;
   assign w_wbin_next  = r_wbin + PW'(w_accept);
   assign w_wgray_next = PW'(bin2gray(32'(w_wbin_next)));
   assign w_rbin       = PW'(gray2bin(32'(rptr_sync)));
   assign w_fill       = w_wbin_next - w_rbin;
   // Full when the write pointer is exactly one lap ahead of the read pointer.
   assign w_full_next  = (w_wgray_next == {~rptr_sync[Addr_Width -: 2], rptr_sync[Addr_Width-2:0]});
   assign w_afull_next = (DEPTH - 32'(w_fill)) <= 32'(AFULL_THRESH);

   always_comb begin
      w_sel_data = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (gnt[i]) w_sel_data = wdata_in[i*Data_Width +: Data_Width];
      end
   end

   always_ff @(posedge wrclk) begin
      if (wr_rst) begin
         r_wbin      <= '0;
         r_rr_last   <= IW'(NUM_REQ-1);
         wptr        <= '0;
         full        <= 1'b0;
         almost_full <= 1'b0;
         wen         <= 1'b0;
         waddr       <= '0;
         wdata       <= '0;
      end else begin
         r_wbin      <= w_wbin_next;
         wptr        <= w_wgray_next;
         full        <= w_full_next;
         almost_full <= w_afull_next;
         wen         <= w_accept;
         if (w_accept) begin
            waddr     <= r_wbin[Addr_Width-1:0];
            wdata     <= w_sel_data;
            r_rr_last <= w_arb_idx;
         end
      end
   end

`ifdef FIFO_WR_ARB_STATS_EN
   always_ff @(posedge wrclk) begin
      if (wr_rst) begin
         stall_cnt <= '0;
         gnt_cnt   <= '0;
      end else begin
         if ((|req) && full && (stall_cnt != 16'hFFFF)) stall_cnt <= stall_cnt + 16'd1;
         for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt[i] && (gnt_cnt[i*16 +: 16] != 16'hFFFF))
               gnt_cnt[i*16 +: 16] <= gnt_cnt[i*16 +: 16] + 16'd1;
         end
      end
   end
`endif
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Randomized bench for fifo_wr_arbiter against an occupancy-level model.
// Build with FIFO_WR_ARB_STATS_EN to also check the stall/grant counters.
module tb_fifo_wr_arbiter;
   localparam int AW = 8, DW = 8, NR = 4, TH = 4, PW = 9;
   localparam int DEPTH = 256, PMOD = 512;

   logic             wrclk = 1'b0;
   logic             wr_rst;
   logic [NR-1:0]    req;
   logic [NR*DW-1:0] wdata_in;
   logic [PW-1:0]    rptr_sync;
   logic [NR-1:0]    gnt;
   logic             wen;
   logic [AW-1:0]    waddr;
   logic [DW-1:0]    wdata;
   logic [PW-1:0]    wptr;
   logic             full;
   logic             almost_full;
`ifdef FIFO_WR_ARB_STATS_EN
   logic [15:0]      stall_cnt;
   logic [NR*16-1:0] gnt_cnt;
   int               m_stall;
   int               m_gcnt[NR];
`endif

   fifo_wr_arbiter #(.Addr_Width(AW), .Data_Width(DW), .NUM_REQ(NR), .AFULL_THRESH(TH)) dut (
      .wrclk       (wrclk),
      .wr_rst      (wr_rst),
      .req         (req),
      .wdata_in    (wdata_in),
      .rptr_sync   (rptr_sync),
      .gnt         (gnt),
      .wen         (wen),
      .waddr       (waddr),
      .wdata       (wdata),
      .wptr        (wptr),
      .full        (full),
      .almost_full (almost_full)
`ifdef FIFO_WR_ARB_STATS_EN
      ,
      .stall_cnt   (stall_cnt),
      .gnt_cnt     (gnt_cnt)
`endif
   );

   always #5 wrclk = ~wrclk;

   int         n_vec = 0, n_err = 0;
   // model: write count (mod 2*DEPTH), last granted requester, read count rb
   int         m_wcount, m_rr, rb, acc_total;
   logic       m_wen, m_full, m_afull, m_prev_ok;
   logic [7:0] m_waddr, m_wdata;
   logic [8:0] prev_wptr;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic logic [8:0] gray9(input int v);
      logic [8:0] b;
      b = 9'(v);
      return b ^ (b >> 1);
   endfunction

   function automatic logic [3:0] model_gnt();
      if (wr_rst || m_full || req == '0) return '0;
      for (int k = 1; k <= NR; k++) begin
         if (req[(m_rr + k) % NR]) return 4'(1 << ((m_rr + k) % NR));
      end
      return '0;
   endfunction

   task automatic model_reset();
      m_wcount = 0; m_rr = NR-1; m_wen = 0; m_full = 0; m_afull = 0;
      m_waddr = 0; m_wdata = 0; m_prev_ok = 0;
`ifdef FIFO_WR_ARB_STATS_EN
      m_stall = 0;
      for (int i = 0; i < NR; i++) m_gcnt[i] = 0;
`endif
   endtask

   task automatic step();
      logic [3:0] eg;
      int idx, fill;
      rptr_sync = gray9(rb);
      @(negedge wrclk);
      eg = model_gnt();
      chk("gnt", 32'(gnt), 32'(eg));
      chk("wen", 32'(wen), 32'(m_wen));
      if (m_wen) begin
         chk("waddr", 32'(waddr), 32'(m_waddr));
         chk("wdata", 32'(wdata), 32'(m_wdata));
      end
      chk("wptr", 32'(wptr), 32'(gray9(m_wcount)));
      chk("full", 32'(full), 32'(m_full));
      chk("almost_full", 32'(almost_full), 32'(m_afull));
      if (m_prev_ok) chk("wptr_onebit", 32'($countones(wptr ^ prev_wptr) <= 1), 32'd1);
`ifdef FIFO_WR_ARB_STATS_EN
      chk("stall_cnt", 32'(stall_cnt), 32'(m_stall));
      for (int i = 0; i < NR; i++) chk("gnt_cnt", 32'(gnt_cnt[i*16 +: 16]), 32'(m_gcnt[i]));
`endif
      prev_wptr = wptr;
      @(posedge wrclk);
      if (wr_rst) begin
         model_reset();
      end else begin
         idx = 0;
         for (int i = 0; i < NR; i++) if (eg[i]) idx = i;
`ifdef FIFO_WR_ARB_STATS_EN
         if (req != '0 && m_full && m_stall < 65535) m_stall++;
         if (eg != '0 && m_gcnt[idx] < 65535) m_gcnt[idx]++;
`endif
         m_wen = (eg != '0);
         if (m_wen) begin
            m_waddr = 8'(m_wcount % DEPTH);
            m_wdata = wdata_in[idx*DW +: DW];
            m_rr    = idx;
            acc_total++;
         end
         m_wcount  = (m_wcount + int'(m_wen)) % PMOD;
         fill      = (m_wcount - rb + PMOD) % PMOD;
         m_full    = (fill == DEPTH);
         m_afull   = (DEPTH - fill) <= TH;
         m_prev_ok = 1;
      end
      #1;
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int h1, h2, cyc, acc0;
      logic saw_full;
      acc_total = 0;
      model_reset();
      wr_rst = 1; req = 4'hF; rb = 0; rptr_sync = '0; wdata_in = 32'h44332211;
      @(posedge wrclk); #1;

      // reset with all requests active
      step(); step();
      chk("rst_gnt", 32'(gnt), 32'd0);
      chk("rst_wen", 32'(wen), 32'd0);
      chk("rst_wptr", 32'(wptr), 32'd0);
      chk("rst_full", 32'(full), 32'd0);
      wr_rst = 0; #1;
      chk("release_gnt", 32'(gnt), 32'h1);

      // round robin order and one-cycle write latency
      for (int c = 0; c < 5; c++) begin
         chk("rr_gnt", 32'(gnt), 32'(1 << (c % 4)));
         step();
         chk("rr_waddr", 32'(waddr), 32'(c));
         chk("rr_wdata", 32'(wdata), 32'(8'h11 * (c % 4 + 1)));
      end

      // fill with one requester
      wr_rst = 1; step(); wr_rst = 0; req = 4'b0001; rb = 0;
      for (int n = 1; n <= 256; n++) begin
         wdata_in = $urandom;
         step();
         if (n == 251) chk("afull_251", 32'(almost_full), 32'd0);
         if (n == 252) chk("afull_252", 32'(almost_full), 32'd1);
         if (n == 255) chk("full_255", 32'(full), 32'd0);
         if (n == 256) chk("full_256", 32'(full), 32'd1);
      end
      for (int n = 0; n < 3; n++) begin
         chk("full_gnt", 32'(gnt), 32'd0);
         step();
         chk("full_wen", 32'(wen), 32'd0);
      end

      // drain release of one entry
      rb = 1; step();
      chk("release_full", 32'(full), 32'd0);
      chk("release_grant", 32'(gnt), 32'h1);
      step();
      chk("refull", 32'(full), 32'd1);
      chk("refull_wen", 32'(wen), 32'd1);
      chk("refull_gnt", 32'(gnt), 32'd0);

      // wrap with read pointer trailing two cycles
      wr_rst = 1; rb = 0; step(); wr_rst = 0;
      h1 = 0; h2 = 0; cyc = 0; acc0 = acc_total; saw_full = 0;
      while (acc_total - acc0 < 600 && cyc < 3000) begin
         req = 4'($urandom_range(1, 15)); wdata_in = $urandom;
         step();
         saw_full |= full;
         rb = h2; h2 = h1; h1 = m_wcount; cyc++;
      end
      chk("wrap_writes", 32'(acc_total - acc0 >= 600), 32'd1);
      chk("wrap_no_full", 32'(saw_full), 32'd0);

      // mid-stream reset at wbin=37
      wr_rst = 1; rb = 0; step(); wr_rst = 0; req = 4'hF;
      h1 = 0; h2 = 0; cyc = 0;
      while (m_wcount != 37 && cyc < 200) begin
         wdata_in = $urandom;
         step();
         rb = h2; h2 = h1; h1 = m_wcount; cyc++;
      end
      chk("reach_37", 32'(m_wcount), 32'd37);
      wr_rst = 1; rb = 0; step();
      chk("midrst_wen", 32'(wen), 32'd0);
      chk("midrst_wptr", 32'(wptr), 32'd0);
      wr_rst = 0; #1;
      chk("midrst_gnt", 32'(gnt), 32'h1);

      // random traffic with slow reader and sporadic resets
      for (int c = 0; c < 1500; c++) begin
         req = 4'($urandom_range(0, 15)); wdata_in = $urandom;
         wr_rst = ($urandom_range(0, 299) == 0);
         step();
         if (wr_rst) rb = 0;
         else if (rb != m_wcount && $urandom_range(0, 3) == 0) rb = (rb + 1) % PMOD;
      end
      wr_rst = 0; req = '0; step();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
